pipe_perf_monitor: RTL and testbench
====================================

Name: pipe_perf_monitor

Overview:
- Synthesizable event counter that consumes status signals from the 5-stage pipelined CPU core (hazard unit stall/flush, control jump/branch, WB-stage retirement).
- Replaces the bench-side stall/flush tallying and cycle-limit stop with hardware counters and a run-length limit.
- Instantiated next to CPU at top level; outputs readable by the bench or a debug bus.

Parameters:
- CNT_W, 32, width of every event counter.
- LIM_W, 16, width of the cycle-limit input.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  CPU start; level; counting enabled only while high
- clear_i  in  1  1-cycle pulse: zero counters, return to IDLE
- stall_i  in  1  hazard unit stall request (PC/IF-ID hold)
- flush_i  in  1  hazard unit IF/ID flush
- jump_i  in  1  control: jump decoded in ID
- branch_i  in  1  control: branch decoded in ID
- retire_i  in  1  MEM/WB stage holds a valid, non-bubble instruction
- limit_i  in  LIM_W  run length in cycles; 0 = unlimited; sampled on IDLE->RUN only
- snap_i  in  1  1-cycle pulse: copy live counters into shadow registers
- cycle_o  out  CNT_W  shadow cycle count
- stall_o  out  CNT_W  shadow stall count
- flush_o  out  CNT_W  shadow flush count
- retire_o  out  CNT_W  shadow retired-instruction count
- running_o  out  1  high in RUN with start_i high
- done_o  out  1  level, high in DONE
- sat_o  out  1  sticky: some live counter saturated

Behaviour:
- Reset (rst_i high at posedge): state IDLE; all live/shadow counters 0; limit register 0; running_o=0, done_o=0, sat_o=0. rst_i overrides every other input.
- FSM states IDLE, RUN, DONE.
  - IDLE -> RUN: start_i high; limit register <= limit_i. No counting in this cycle.
  - RUN: each cycle with start_i high, cycle counter +1 and events counted. start_i low freezes all counters, state stays RUN.
  - RUN -> DONE: limit != 0 and live cycle count reaches limit on this increment. DONE entered next posedge, so cycle count = limit exactly.
  - DONE: counters frozen; on entry shadows auto-loaded with final values, same edge. Held until clear_i.
  - Any state + clear_i -> IDLE, live counters 0, sat_o 0; shadows retained until next snap/DONE.
- Event rules, per counted cycle:
  - stall: stall_i & ~jump_i & ~branch_i (control-hazard holds are not data stalls).
  - flush: flush_i.
  - retire: retire_i.
  - Several events in one cycle each increment their own counter.
- Arithmetic: unsigned CNT_W. At all-ones a counter holds (no wrap) and sat_o sets.
- snap_i: shadows <= live values as of that edge, before the same-edge increment. snap_i in DONE is harmless.
- Simultaneous events:
  - clear_i with snap_i: snapshot takes pre-clear values.
  - clear_i with start_i in IDLE: clear wins, stay IDLE.
  - Limit hit with snap_i: DONE auto-load wins; values identical anyway.
- running_o and done_o are registered state decodes; no combinational path from inputs.

Decomposition:
- Package pipe_perf_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default CNT_W, LIM_W.
- Sub-module sat_counter (CNT_W; inputs en, clr; outputs count, sat). Instantiated four times: cycle, stall, flush, retire.

Test Plan:
- Reset mid-RUN after 7 counted cycles -> next edge all outputs 0, state IDLE; start_i still high -> RUN following edge.
- limit_i=10, start_i held, stall_i high cycles 3-4 with jump_i low, flush_i high cycle 6 -> done_o rises after 10 counted cycles; cycle_o=10, stall_o=2, flush_o=1.
- stall_i high with branch_i high for 3 cycles, then stall_i with jump_i for 2 -> stall_o=0 after snap.
- start_i low 4 cycles mid-run, limit_i=10 -> done_o delayed 4 cycles; cycle_o=10.
- CNT_W=4, limit 0, retire_i always high for 20 cycles -> retire_o=15, sat_o=1; clear_i -> sat_o=0, IDLE.
- snap_i at live cycle 5 together with clear_i -> cycle_o=5, live counters 0, done_o=0.

Source files
------------

// File: rtl/pipe_perf_pkg.sv
// Shared types and defaults for the pipeline performance monitor.
// State encoding and default counter / limit widths.
package pipe_perf_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int DEF_LIM_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_perf_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports: clk_i, rst_i, en, clr -> count (current), nxt (next), sat (at max).
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] nxt,
    output logic             sat
);

    logic [CNT_W-1:0] cnt_q;

    assign sat   = &cnt_q;
    assign count = cnt_q;
    assign nxt   = (en && !sat) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= nxt;
        end
    end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline event counters (cycles, data stalls, flushes, retires) with
// run-length limit and shadow snapshot registers.
// Inputs: clk_i, rst_i, start_i, clear_i, stall_i, flush_i, jump_i,
// branch_i, retire_i, limit_i, snap_i. Outputs: shadow counts
// cycle_o/stall_o/flush_o/retire_o, running_o, done_o, sat_o.
import pipe_perf_pkg::*;

module pipe_perf_monitor #(
    parameter int CNT_W = DEF_CNT_W,
    parameter int LIM_W = DEF_LIM_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             retire_i,
    input  logic [LIM_W-1:0] limit_i,
    input  logic             snap_i,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] stall_o,
    output logic [CNT_W-1:0] flush_o,
    output logic [CNT_W-1:0] retire_o,
    output logic             running_o,
    output logic             done_o,
    output logic             sat_o
);

    localparam int CMP_W = ((CNT_W > LIM_W) ? CNT_W : LIM_W) + 1;

    state_t           state_q;
    state_t           state_d;
    logic [LIM_W-1:0] lim_q;
    logic             running_q;
    logic             done_q;

    logic             cnt_en;
    logic             stall_ev;
    logic             hit;

    logic [CNT_W-1:0] cyc_q, cyc_n;
    logic [CNT_W-1:0] stl_q, stl_n;
    logic [CNT_W-1:0] fls_q, fls_n;
    logic [CNT_W-1:0] ret_q, ret_n;
    logic             cyc_sat, stl_sat, fls_sat, ret_sat;

    logic [CNT_W-1:0] cyc_sh, stl_sh, fls_sh, ret_sh;

    assign cnt_en = (state_q == RUN) && start_i && !clear_i;

    // Holds caused by a jump/branch are control hazards, not data stalls.
    assign stall_ev = stall_i && !jump_i && !branch_i;

    // Limit reached on this increment; a saturated cycle counter never
    // advances, so it cannot reach a limit beyond its range.
    assign hit = cnt_en && (lim_q != '0) && !cyc_sat &&
                 ((CMP_W'(cyc_q) + CMP_W'(1)) == CMP_W'(lim_q));

    sat_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (cnt_en),
        .clr   (clear_i),
        .count (cyc_q),
        .nxt   (cyc_n),
        .sat   (cyc_sat)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stl (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (cnt_en && stall_ev),
        .clr   (clear_i),
        .count (stl_q),
        .nxt   (stl_n),
        .sat   (stl_sat)
    );

    sat_counter #(.CNT_W(CNT_W)) u_fls (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (cnt_en && flush_i),
        .clr   (clear_i),
        .count (fls_q),
        .nxt   (fls_n),
        .sat   (fls_sat)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ret (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (cnt_en && retire_i),
        .clr   (clear_i),
        .count (ret_q),
        .nxt   (ret_n),
        .sat   (ret_sat)
    );

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_i) state_d = RUN;
                RUN:     if (hit) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            lim_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            cyc_sh    <= '0;
            stl_sh    <= '0;
            fls_sh    <= '0;
            ret_sh    <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN) && start_i;
            done_q    <= (state_d == DONE);
            if (state_q == IDLE && start_i && !clear_i) begin
                lim_q <= limit_i;
            end
            // DONE entry captures the final (post-increment) values.
            if (hit) begin
                cyc_sh <= cyc_n;
                stl_sh <= stl_n;
                fls_sh <= fls_n;
                ret_sh <= ret_n;
            end else if (snap_i) begin
                cyc_sh <= cyc_q;
                stl_sh <= stl_q;
                fls_sh <= fls_q;
                ret_sh <= ret_q;
            end
        end
    end

    assign cycle_o   = cyc_sh;
    assign stall_o   = stl_sh;
    assign flush_o   = fls_sh;
    assign retire_o  = ret_sh;
    assign running_o = running_q;
    assign done_o    = done_q;
    assign sat_o     = cyc_sat | stl_sat | fls_sat | ret_sat;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Randomised + directed bench for pipe_perf_monitor (32-bit and 4-bit
// instances) against a behavioural count model.
module tb_pipe_perf_monitor;

    logic        clk = 1'b0;
    logic        rst, start, clear, stall, flush, jump, branch, retire, snap;
    logic [15:0] limit;

    logic [31:0] b_cyc, b_stl, b_fls, b_ret;
    logic        b_run, b_done, b_sat;
    logic [3:0]  s_cyc, s_stl, s_fls, s_ret;
    logic        s_run, s_done, s_sat;

    always #5 clk = ~clk;

    pipe_perf_monitor u_big (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .stall_i(stall), .flush_i(flush), .jump_i(jump),
        .branch_i(branch), .retire_i(retire), .limit_i(limit),
        .snap_i(snap), .cycle_o(b_cyc), .stall_o(b_stl),
        .flush_o(b_fls), .retire_o(b_ret), .running_o(b_run),
        .done_o(b_done), .sat_o(b_sat)
    );

    pipe_perf_monitor #(.CNT_W(4), .LIM_W(16)) u_small (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .stall_i(stall), .flush_i(flush), .jump_i(jump),
        .branch_i(branch), .retire_i(retire), .limit_i(limit),
        .snap_i(snap), .cycle_o(s_cyc), .stall_o(s_stl),
        .flush_o(s_fls), .retire_o(s_ret), .running_o(s_run),
        .done_o(s_done), .sat_o(s_sat)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    // Model: per instance k, mode 0=idle 1=run 2=done, plain counts.
    longint cap[2];
    longint live[2][4];
    longint shad[2][4];
    int     mode[2];
    longint lim[2];
    bit     mrun[2];
    bit     mdone[2];

    function automatic void bump(int k, int i, bit c);
        if (c && live[k][i] < cap[k]) live[k][i]++;
    endfunction

    function automatic void model_step(int k);
        longint old[4];
        bit     hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) old[i] = live[k][i];
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                live[k][i] = 0;
                shad[k][i] = 0;
            end
            mode[k]  = 0;
            lim[k]   = 0;
            mrun[k]  = 1'b0;
            mdone[k] = 1'b0;
            return;
        end
        if (clear) begin
            for (int i = 0; i < 4; i++) live[k][i] = 0;
            mode[k] = 0;
            if (snap) for (int i = 0; i < 4; i++) shad[k][i] = old[i];
        end else if (mode[k] == 0) begin
            if (start) begin
                mode[k] = 1;
                lim[k]  = limit;
            end
            if (snap) for (int i = 0; i < 4; i++) shad[k][i] = old[i];
        end else if (mode[k] == 1) begin
            if (start) begin
                if (live[k][0] < cap[k]) begin
                    live[k][0]++;
                    hit = (lim[k] != 0) && (live[k][0] == lim[k]);
                end
                bump(k, 1, stall && !jump && !branch);
                bump(k, 2, flush);
                bump(k, 3, retire);
            end
            if (hit) begin
                mode[k] = 2;
                for (int i = 0; i < 4; i++) shad[k][i] = live[k][i];
            end else if (snap) begin
                for (int i = 0; i < 4; i++) shad[k][i] = old[i];
            end
        end else if (snap) begin
            for (int i = 0; i < 4; i++) shad[k][i] = old[i];
        end
        mrun[k]  = (mode[k] == 1) && start;
        mdone[k] = (mode[k] == 2);
    endfunction

    function automatic bit msat(int k);
        bit s;
        s = 1'b0;
        for (int i = 0; i < 4; i++) if (live[k][i] == cap[k]) s = 1'b1;
        return s;
    endfunction

    task automatic check_all();
        chk("b_cycle", 64'(b_cyc), shad[0][0]);
        chk("b_stall", 64'(b_stl), shad[0][1]);
        chk("b_flush", 64'(b_fls), shad[0][2]);
        chk("b_retire", 64'(b_ret), shad[0][3]);
        chk("b_running", 64'(b_run), longint'(mrun[0]));
        chk("b_done", 64'(b_done), longint'(mdone[0]));
        chk("b_sat", 64'(b_sat), longint'(msat(0)));
        chk("s_cycle", 64'(s_cyc), shad[1][0]);
        chk("s_stall", 64'(s_stl), shad[1][1]);
        chk("s_flush", 64'(s_fls), shad[1][2]);
        chk("s_retire", 64'(s_ret), shad[1][3]);
        chk("s_running", 64'(s_run), longint'(mrun[1]));
        chk("s_done", 64'(s_done), longint'(mdone[1]));
        chk("s_sat", 64'(s_sat), longint'(msat(1)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; clear = 0; stall = 0; flush = 0;
        jump = 0; branch = 0; retire = 0; snap = 0; limit = 0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1;
        tick();
        clear = 0;
    endtask

    initial begin
        cap[0] = 64'hFFFF_FFFF;
        cap[1] = 15;
        idle_inputs();
        rst = 1;
        tick();
        chk("rst_cycle", 64'(b_cyc), 0);
        chk("rst_done", 64'(b_done), 0);
        rst = 0;

        // Reset mid-run after 7 counted cycles.
        start = 1;
        tick();
        repeat (7) tick();
        rst = 1;
        tick();
        chk("midrst_run", 64'(b_run), 0);
        chk("midrst_sat", 64'(b_sat), 0);
        rst = 0;
        tick();
        chk("rst_rerun", 64'(b_run), 1);

        // limit 10, stalls on counted cycles 3-4, flush on 6.
        do_clear();
        start = 1;
        limit = 10;
        tick();
        for (int i = 1; i <= 10; i++) begin
            stall = (i == 3 || i == 4);
            flush = (i == 6);
            tick();
        end
        stall = 0;
        flush = 0;
        chk("lim_done", 64'(b_done), 1);
        chk("lim_cycle", 64'(b_cyc), 10);
        chk("lim_stall", 64'(b_stl), 2);
        chk("lim_flush", 64'(b_fls), 1);
        repeat (3) tick();
        chk("done_hold", 64'(b_cyc), 10);

        // Control-hazard holds are not counted as stalls.
        do_clear();
        start = 1;
        tick();
        stall = 1;
        branch = 1;
        repeat (3) tick();
        branch = 0;
        jump = 1;
        repeat (2) tick();
        stall = 0;
        jump = 0;
        snap = 1;
        tick();
        snap = 0;
        chk("ctl_stall", 64'(b_stl), 0);
        chk("ctl_cycle", 64'(b_cyc), 5);

        // start_i low for 4 cycles delays DONE.
        do_clear();
        start = 1;
        limit = 10;
        tick();
        repeat (5) tick();
        start = 0;
        repeat (4) tick();
        chk("pause_done", 64'(b_done), 0);
        start = 1;
        repeat (4) tick();
        chk("pause_early", 64'(b_done), 0);
        tick();
        chk("pause_cyc", 64'(b_cyc), 10);
        chk("pause_fin", 64'(b_done), 1);

        // 4-bit saturation.
        do_clear();
        start = 1;
        retire = 1;
        tick();
        repeat (20) tick();
        snap = 1;
        tick();
        snap = 0;
        chk("sat_ret", 64'(s_ret), 15);
        chk("sat_flag", 64'(s_sat), 1);
        retire = 0;
        start = 0;
        clear = 1;
        tick();
        clear = 0;
        chk("sat_clr", 64'(s_sat), 0);
        chk("sat_idle", 64'(s_run), 0);

        // snap together with clear takes pre-clear values.
        do_clear();
        start = 1;
        tick();
        repeat (5) tick();
        start = 0;
        snap = 1;
        clear = 1;
        tick();
        clear = 0;
        chk("snapclr_cyc", 64'(b_cyc), 5);
        chk("snapclr_done", 64'(b_done), 0);
        tick();
        chk("snapclr_live", 64'(b_cyc), 0);
        snap = 0;

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            rst    = ($urandom_range(0, 399) == 0);
            clear  = ($urandom_range(0, 59) == 0);
            snap   = ($urandom_range(0, 19) == 0);
            start  = ($urandom_range(0, 99) < 85);
            stall  = ($urandom_range(0, 99) < 30);
            jump   = ($urandom_range(0, 99) < 15);
            branch = ($urandom_range(0, 99) < 15);
            flush  = ($urandom_range(0, 99) < 15);
            retire = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 9) < 3) limit = 16'd0;
            else limit = 16'($urandom_range(1, 60));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec,
                 n_bad);
        $finish;
    end

endmodule
